// File: rtl/dec_6_64_slot.sv
// dec_6_64_slot: entry index -> one-hot column mask for BRAM write steering, plus the CAM entry-valid bitmap.
// Latency: 1 cycle, registered mask; bitmap and count update on the accept edge.
// Backpressure: single output stage, cmd_ready = !oh_valid || oh_ready. DEC_CLR_ALL_EN enables op 11 (CLR_ALL).
module dec_6_64_slot #(
  parameter int N_ENTRIES = 64,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDX_W-1:0]     cmd_idx,
  output logic                 oh_valid,
  input  logic                 oh_ready,
  output logic [N_ENTRIES-1:0] oh_mask,
  output logic [1:0]           oh_op,
  output logic [N_ENTRIES-1:0] bitmap,
  output logic [IDX_W:0]       count,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam logic [1:0] OP_SET     = 2'b01;
  localparam logic [1:0] OP_CLR     = 2'b10;
  localparam logic [1:0] OP_CLR_ALL = 2'b11;
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N_ENTRIES);

  generate
    if (N_ENTRIES != 64 || IDX_W != 6) begin : g_bad_cfg
      $error("dec_6_64_slot supports only N_ENTRIES=64, IDX_W=6");
    end
  endgenerate

  logic                 accept;
  logic                 hit;
  logic                 redundant;
  logic [N_ENTRIES-1:0] mask_nxt;
  logic [N_ENTRIES-1:0] bitmap_nxt;
  logic [IDX_W:0]       count_nxt;

  assign cmd_ready = !oh_valid || oh_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign hit       = bitmap[cmd_idx];
  assign full      = (count == CNT_MAX);
  assign empty     = (count == '0);

  // count only moves when the addressed bit really flips, so it can never wrap
  always_comb begin
    mask_nxt   = '0;
    bitmap_nxt = bitmap;
    count_nxt  = count;
    redundant  = 1'b0;
    case (cmd_op)
      OP_SET: begin
        mask_nxt[cmd_idx] = 1'b1;
        if (hit) begin
          redundant = 1'b1;
        end else begin
          bitmap_nxt[cmd_idx] = 1'b1;
          count_nxt           = count + CNT_ONE;
        end
      end
      OP_CLR: begin
        mask_nxt[cmd_idx] = 1'b1;
        if (!hit) begin
          redundant = 1'b1;
        end else begin
          bitmap_nxt[cmd_idx] = 1'b0;
          count_nxt           = count - CNT_ONE;
        end
      end
      OP_CLR_ALL: begin
`ifdef DEC_CLR_ALL_EN
        mask_nxt   = '1;
        bitmap_nxt = '0;
        count_nxt  = '0;
        redundant  = (count == '0);
`else
        redundant  = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oh_valid <= 1'b0;
      oh_mask  <= '0;
      oh_op    <= 2'b00;
      bitmap   <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept && redundant;
      if (accept) begin
        oh_valid <= 1'b1;
        oh_mask  <= mask_nxt;
        oh_op    <= cmd_op;
        bitmap   <= bitmap_nxt;
        count    <= count_nxt;
      end else if (oh_ready) begin
        oh_valid <= 1'b0;
      end
    end
  end

endmodule
